// File: rtl/sysid_checker.sv
// sysid_checker: reads the sysid ID and timestamp words over Avalon-MM and
// compares them with the values this build expects.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd1240784590,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1327442508,
    parameter int          TIMEOUT_CYCLES     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout,
    output logic [31:0] read_id,
    output logic [31:0] read_timestamp
);
    typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, FINISH} state_t;

    state_t      state_q, state_d;
    logic [15:0] wait_q, wait_d, wait_inc;
    logic        pass_q, pass_d;
    logic        id_mm_q, id_mm_d;
    logic        ts_mm_q, ts_mm_d;
    logic        to_q, to_d;
    logic [31:0] id_q, id_d;
    logic [31:0] ts_q, ts_d;
    logic        expired;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            wait_q  <= '0;
            pass_q  <= 1'b0;
            id_mm_q <= 1'b0;
            ts_mm_q <= 1'b0;
            to_q    <= 1'b0;
            id_q    <= '0;
            ts_q    <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            pass_q  <= pass_d;
            id_mm_q <= id_mm_d;
            ts_mm_q <= ts_mm_d;
            to_q    <= to_d;
            id_q    <= id_d;
            ts_q    <= ts_d;
        end
    end

    assign wait_inc = wait_q + 16'd1;
    assign expired  = wait_inc == 16'(TIMEOUT_CYCLES);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        pass_d  = pass_q;
        id_mm_d = id_mm_q;
        ts_mm_d = ts_mm_q;
        to_d    = to_q;
        id_d    = id_q;
        ts_d    = ts_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RD_ID;
                    wait_d  = '0;
                    pass_d  = 1'b0;
                    id_mm_d = 1'b0;
                    ts_mm_d = 1'b0;
                    to_d    = 1'b0;
                end
            end
            RD_ID: begin
                if (!avm_waitrequest) begin
                    id_d    = avm_readdata;
                    id_mm_d = avm_readdata != EXPECTED_ID;
                    wait_d  = '0;
                    state_d = RD_TS;
                end else begin
                    wait_d  = wait_inc;
                    to_d    = expired;
                    state_d = expired ? FINISH : RD_ID;
                end
            end
            RD_TS: begin
                if (!avm_waitrequest) begin
                    ts_d    = avm_readdata;
                    ts_mm_d = avm_readdata != EXPECTED_TIMESTAMP;
                    state_d = FINISH;
                end else begin
                    wait_d  = wait_inc;
                    to_d    = expired;
                    state_d = expired ? FINISH : RD_TS;
                end
            end
            default: state_d = IDLE;
        endcase
        // Resolve pass on entry to FINISH so it is valid alongside done.
        if (state_d == FINISH && state_q != FINISH)
            pass_d = !(id_mm_d || ts_mm_d || to_d);
    end

    assign avm_read       = state_q == RD_ID || state_q == RD_TS;
    assign avm_address    = state_q == RD_TS;
    assign busy           = state_q != IDLE;
    assign done           = state_q == FINISH;
    assign pass           = pass_q;
    assign id_mismatch    = id_mm_q;
    assign ts_mismatch    = ts_mm_q;
    assign timeout        = to_q;
    assign read_id        = id_q;
    assign read_timestamp = ts_q;
endmodule

// File: doc/sysid_checker.md
SYSID_CHECKER -- requirements
Module: sysid_checker

Interface
REQ-001 Parameter EXPECTED_ID, default 32'd1240784590, system ID value the design is built against.
REQ-002 Parameter EXPECTED_TIMESTAMP, default 32'd1327442508, build timestamp the design is built against.
REQ-003 Parameter TIMEOUT_CYCLES, default 16, maximum cycles a read may stall on waitrequest (1..65535).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  single-cycle pulse requesting a check sequence.
REQ-007 avm_address  output  1  word address to the sysid control slave: 0 = ID, 1 = timestamp.
REQ-008 avm_read  output  1  Avalon-MM read request.
REQ-009 avm_waitrequest  input  1  slave stall; tie to 0 for a zero-wait slave.
REQ-010 avm_readdata  input  32  read data, valid in the cycle avm_read=1 and avm_waitrequest=0.
REQ-011 busy  output  1  check sequence in progress.
REQ-012 done  output  1  one-cycle pulse when a sequence ends.
REQ-013 pass  output  1  last sequence matched both values with no timeout.
REQ-014 id_mismatch, ts_mismatch, timeout  output  1 each  sticky error flags from the last sequence.
REQ-015 read_id, read_timestamp  output  32 each  values captured by the last sequence.

Function
REQ-016 The FSM SHALL have states IDLE, RD_ID, RD_TS, FINISH.
REQ-017 In IDLE, start=1 SHALL move to RD_ID next cycle, clear pass, id_mismatch, ts_mismatch and timeout, and zero the wait counter.
REQ-018 start SHALL be ignored in every state other than IDLE.
REQ-019 In RD_ID: avm_read=1, avm_address=0; the FSM SHALL stay while avm_waitrequest=1 and SHALL remain registered (no combinational path from avm_waitrequest to avm_read or avm_address).
REQ-020 In RD_ID with avm_waitrequest=0, avm_readdata SHALL be latched into read_id, id_mismatch set to (avm_readdata != EXPECTED_ID), wait counter zeroed, and the FSM SHALL enter RD_TS.
REQ-021 In RD_TS: avm_read=1, avm_address=1; with avm_waitrequest=0 latch into read_timestamp, set ts_mismatch to (avm_readdata != EXPECTED_TIMESTAMP), and enter FINISH.
REQ-022 Each cycle in RD_ID/RD_TS with avm_waitrequest=1 SHALL increment a 16-bit wait counter; when it reaches TIMEOUT_CYCLES, timeout SHALL set, the read SHALL be abandoned (avm_read=0 next cycle) and the FSM SHALL go to FINISH without reading the remaining word.
REQ-023 A timeout in RD_ID SHALL leave read_id and read_timestamp unchanged from their previous values; ts_mismatch SHALL stay 0.
REQ-024 FINISH SHALL last exactly one cycle: done=1, pass set to NOT(id_mismatch OR ts_mismatch OR timeout), then return to IDLE.
REQ-025 avm_read SHALL be 0 in IDLE and FINISH.
REQ-026 busy SHALL be 1 in RD_ID, RD_TS and FINISH, 0 in IDLE.
REQ-027 With zero-wait slave, start at cycle N SHALL give avm_read in cycles N+1 (addr 0) and N+2 (addr 1), done in cycle N+3.
REQ-028 Result outputs (pass, flags, read_id, read_timestamp) SHALL hold until the next accepted start.

Reset
REQ-029 reset=1 SHALL immediately force state IDLE, avm_read=0, avm_address=0, busy=0, done=0, pass=0, all flags 0, read_id=0, read_timestamp=0, wait counter 0.
REQ-030 reset asserted mid-read SHALL abort the transaction with avm_read low asynchronously; no done pulse SHALL follow deassertion.
REQ-031 After reset deassertion the block SHALL idle until start.

Verification
REQ-032 Zero-wait slave returning 1240784590/1327442508, start pulse -> reads at addr 0 then 1, done at N+3, pass=1, flags 0, read_id=32'd1240784590.
REQ-033 Slave returns 32'h0000_0000 for ID -> id_mismatch=1, ts_mismatch=0, pass=0, read_id=0.
REQ-034 waitrequest held 3 cycles on each read -> avm_read/avm_address stable during stall, done at N+9, pass=1.
REQ-035 waitrequest stuck 1 during RD_TS, TIMEOUT_CYCLES=16 -> timeout=1 after 16 stalled cycles, done pulse, pass=0, read_id captured.
REQ-036 start pulsed again while busy -> ignored, single done pulse; reset mid-RD_ID -> all outputs 0, no done.
